// File: rtl/riscv_pkg.sv
// riscv_pkg: core-wide widths, the canonical NOP and the reset polarity.
package riscv_pkg;
    localparam int          XLEN       = 32;
    localparam int          INS_W      = 32;
    localparam logic [31:0] NOP_INS    = 32'h0000_0013;
    localparam logic        RST_ACTIVE = 1'b0;
endpackage

// File: rtl/sync_fifo_ptr.sv
// sync_fifo_ptr: circular-buffer pointers and occupancy with flush; flush beats push/pop.
module sync_fifo_ptr
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic          wr_en_o,
    output logic [PW-1:0] wr_ptr_o,
    output logic [PW-1:0] rd_ptr_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_en;

    // full is registered-only, so a pop at DEPTH never frees room for a same-cycle push
    assign full_o   = count_q == CW'(DEPTH);
    assign empty_o  = count_q == '0;
    assign wr_en_o  = push_i & ~full_o & ~flush_i;
    assign rd_en    = pop_i & ~empty_o & ~flush_i;
    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

    always_comb begin
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + PW'(wr_en_o);
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + PW'(rd_en);
        count_d  = flush_i ? '0 : count_q + CW'(wr_en_o) - CW'(rd_en);
    end

    always_ff @(posedge clk or negedge rst)
        if (rst == RST_ACTIVE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
endmodule

// File: rtl/if_prefetch_buf.sv
// if_prefetch_buf: show-ahead {address, instruction} queue between fetch and if_id.
module if_prefetch_buf
    import riscv_pkg::*;
#(
    parameter  int            DEPTH = 4,
    parameter  int            AW    = XLEN,
    parameter  int            IW    = INS_W,
    parameter  logic [IW-1:0] NOP   = IW'(NOP_INS),
    localparam int            PW    = $clog2(DEPTH),
    localparam int            CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump_en,
    input  logic          hold_en,
    input  logic          fetch_valid_i,
    input  logic [AW-1:0] ins_addr_i,
    input  logic [IW-1:0] ins_i,
    output logic          full_o,
    output logic          ins_valid_o,
    output logic [IW-1:0] ins_o,
    output logic [AW-1:0] ins_addr_o,
    output logic [CW-1:0] count_o
);
    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [IW-1:0] ins_mem_q  [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, empty;

    sync_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fetch_valid_i),
        .pop_i   (~hold_en),
        .flush_i (jump_en),
        .wr_en_o (wr_en),
        .wr_ptr_o(wr_ptr),
        .rd_ptr_o(rd_ptr),
        .count_o (count_o),
        .full_o  (full_o),
        .empty_o (empty)
    );

    always_ff @(posedge clk)
        if (wr_en) begin
            addr_mem_q[wr_ptr] <= ins_addr_i;
            ins_mem_q[wr_ptr]  <= ins_i;
        end

    // no bypass: a pair becomes visible only once it sits in the array
    assign ins_valid_o = ~empty;
    assign ins_o       = empty ? NOP : ins_mem_q[rd_ptr];
    assign ins_addr_o  = empty ? '0  : addr_mem_q[rd_ptr];
endmodule
